multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
- Control FSM that sequences the existing CPU datapath (PC, IR, regfile, ALU, memory) as a multi-cycle machine: IF, ID, EXE, MEM, WB.
- Instruction fetch and data access share a single memory port through a req/ack handshake.
- Sits between the instruction decoder and the datapath enables.
- Also provides run/halt/single-step debug control, a retired-instruction counter and an error trap.

Parameters:
MEM_TIMEOUT, 16, cycles a memory request may wait for mem_ack before trapping to ERR (>=2)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
run  in  1  1 = free-run; 0 = halt after current instruction
step  in  1  one-cycle pulse; in IDLE with run=0, executes exactly one instruction
dec_valid  in  1  IR holds a legal instruction
dec_load  in  1  IR is a load
dec_store  in  1  IR is a store
dec_wb  in  1  IR writes regfile (ALU-type, LUI, load)
dec_jbr  in  1  branch/jump taken (resolved from regfile values)
mem_ack  in  1  memory completed current request this cycle
mem_req  out  1  memory request
mem_we  out  1  request is a write
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_wen  out  1  latch memory read data into IR
pc_wen  out  1  update PC
pc_sel  out  1  0 = PC+4, 1 = branch/jump target
rf_wen  out  1  regfile write
wb_sel  out  1  0 = ALU result, 1 = memory data
state  out  3  current state encoding
halted  out  1  FSM in IDLE
exc  out  1  sticky error flag
retire_cnt  out  CNT_W  instructions retired, wraps modulo 2^CNT_W

Behaviour:
- State encoding: IDLE=0, IF=1, ID=2, EXE=3, MEM=4, WB=5, ERR=6. Value 7 is unreachable and recovers to IDLE.
- Reset (resetn low at posedge):
  - state=IDLE, retire_cnt=0, exc=0, timeout counter=0.
  - All enables (mem_req, ir_wen, pc_wen, rf_wen, mem_we) are gated by resetn, so they are 0 in any cycle where resetn=0.
  - Reset mid-operation aborts the instruction with no PC, regfile or memory write.
- IDLE:
  - halted=1, all enables 0.
  - run|step -> IF.
- IF:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - ir_wen=mem_ack (combinational).
  - On mem_ack -> ID.
- ID:
  - dec_valid=0 -> ERR; else -> EXE.
  - One cycle, no enables.
- EXE:
  - One cycle; ALU settles.
  - dec_load|dec_store -> MEM.
  - Else dec_wb -> WB.
  - Else retire here with pc_wen=1, pc_sel=dec_jbr.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=dec_store.
  - On mem_ack: store retires (pc_wen=1, pc_sel=0); load -> WB.
- WB:
  - rf_wen=1, wb_sel=dec_load.
  - Retire with pc_wen=1, pc_sel=0.
- Retire cycle:
  - pc_wen pulses exactly one cycle.
  - retire_cnt increments on the next edge, wrapping from all-ones to 0.
  - Next state is IF if run=1, else IDLE.
  - step is sampled only in IDLE, so a step pulse executes exactly one instruction.
- Timeout:
  - Counter clears on entry to IF/MEM and increments each IF/MEM cycle without mem_ack.
  - If the count reaches MEM_TIMEOUT-1 with no ack -> ERR.
  - mem_ack in the same cycle as expiry wins (normal transition).
- ERR:
  - exc=1, all enables 0.
  - Held until reset; run and step are ignored.
- mem_ack while mem_req=0 is ignored.
- Latency with zero-wait memory:
  - ALU/LUI: 4 cycles.
  - Branch/jump: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- Dropping run mid-instruction never aborts; the current instruction completes, then the FSM goes to IDLE.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..ERR, 3-bit);
  - mem_addr_sel, pc_sel and wb_sel select constants;
  - default MEM_TIMEOUT.
- One sub-module: mc_mem_timer, holding the timeout counter with clear/enable/expired. The FSM and output logic remain in multi_cycle_ctrl.

Test Plan:
- ALU-type instruction (run=1, dec_valid=1, dec_wb=1, mem_ack same cycle) -> state 1,2,3,5,1. In the WB cycle rf_wen=1, wb_sel=0, pc_wen=1, pc_sel=0. retire_cnt 0->1. Repeats every 4 cycles.
- Load with mem_ack delayed 3 cycles in MEM -> MEM lasts 4 cycles with mem_addr_sel=1, mem_we=0. WB follows with rf_wen=1, wb_sel=1. Total 8 cycles.
- Store (dec_store=1, dec_wb=0) -> mem_we=1 only in MEM. pc_wen on the ack cycle. rf_wen is never asserted.
- Taken branch (dec_jbr=1, dec_wb=0) -> pc_wen=1, pc_sel=1 in EXE; 3-cycle instruction. With dec_jbr=0, pc_sel=0.
- Timeout with MEM_TIMEOUT=16 and mem_ack held 0 in IF -> enters ERR after 16 IF cycles. exc=1, no pc_wen/rf_wen. Stays in ERR for 100 cycles with run=1. resetn low clears it to IDLE, exc=0.
- Single-step and reset:
  - run=0 with one step pulse -> exactly one instruction retires, retire_cnt +1, then IDLE with halted=1.
  - resetn low during MEM -> enables 0 that cycle, IDLE next, retire_cnt=0.
  - retire_cnt preset near all-ones wraps to 0.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl_pkg
// Purpose  : Shared definitions for the multi-cycle CPU control slice:
//            FSM state encoding, datapath mux select values and the default
//            memory-timeout depth.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multi_cycle_ctrl_pkg;

    // FSM state encoding. ST_BAD is never entered; it exists so the encoding
    // space is fully named and the FSM can recover from it explicitly.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EXE  = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_ERR  = 3'd6,
        ST_BAD  = 3'd7
    } state_t;

    // Memory address mux: instruction fetch uses PC, data access uses ALU.
    localparam logic C_ADDR_SEL_PC  = 1'b0;
    localparam logic C_ADDR_SEL_ALU = 1'b1;

    // Next-PC mux: sequential or branch/jump target.
    localparam logic C_PC_SEL_SEQ   = 1'b0;
    localparam logic C_PC_SEL_TGT   = 1'b1;

    // Regfile write-back mux: ALU result or memory read data.
    localparam logic C_WB_SEL_ALU   = 1'b0;
    localparam logic C_WB_SEL_MEM   = 1'b1;

    // Cycles a memory request may wait for an acknowledge before trapping.
    localparam int C_MEM_TIMEOUT_DEFAULT = 16;

    // States that own the shared memory port.
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_IF) || (s == ST_MEM);
    endfunction

endpackage : multi_cycle_ctrl_pkg
`default_nettype wire

// File: rtl/multi_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl_if
// Purpose  : Bundle of all control-FSM signals: debug control, decoder
//            flags, memory handshake, datapath enables and status.
// Modports : master - the controller (drives enables/status)
//            slave  - decoder/datapath/memory side (drives flags and ack)
// Revision : 1.0 - initial release
// ============================================================================
interface multi_cycle_ctrl_if #(
    parameter int CNT_W = 32
);
    import multi_cycle_ctrl_pkg::*;

    // Debug control
    logic             run;
    logic             step;
    // Decoder flags
    logic             dec_valid;
    logic             dec_load;
    logic             dec_store;
    logic             dec_wb;
    logic             dec_jbr;
    // Memory handshake
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    // Datapath enables / selects
    logic             ir_wen;
    logic             pc_wen;
    logic             pc_sel;
    logic             rf_wen;
    logic             wb_sel;
    // Status
    state_t           state;
    logic             halted;
    logic             exc;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        input  run, step,
        input  dec_valid, dec_load, dec_store, dec_wb, dec_jbr,
        input  mem_ack,
        output mem_req, mem_we, mem_addr_sel,
        output ir_wen, pc_wen, pc_sel, rf_wen, wb_sel,
        output state, halted, exc, retire_cnt
    );

    modport slave (
        output run, step,
        output dec_valid, dec_load, dec_store, dec_wb, dec_jbr,
        output mem_ack,
        input  mem_req, mem_we, mem_addr_sel,
        input  ir_wen, pc_wen, pc_sel, rf_wen, wb_sel,
        input  state, halted, exc, retire_cnt
    );

endinterface : multi_cycle_ctrl_if
`default_nettype wire

// File: rtl/multi_cycle_ctrl_mem_timer.sv
`default_nettype none
// ============================================================================
// Module   : mc_mem_timer
// Purpose  : Counts cycles a memory request has waited without an ack.
//            expired_o is high in the cycle the count equals MEM_TIMEOUT-1,
//            i.e. the MEM_TIMEOUT-th consecutive waiting cycle.
// Ports    : clk, resetn (sync, active-low)
//            clr_i     - restart the count (state change)
//            en_i      - a request is waiting this cycle
//            expired_o - wait budget exhausted this cycle
// Revision : 1.0 - initial release
// ============================================================================
module mc_mem_timer
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = C_MEM_TIMEOUT_DEFAULT
) (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      expired_o
);

    // Counter only needs to reach MEM_TIMEOUT-1.
    localparam int                 C_CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(MEM_TIMEOUT - 1);

    logic [C_CNT_W-1:0] cnt_q;
    logic [C_CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            // Saturate at the last value; the FSM leaves on expiry anyway.
            cnt_d = cnt_q + C_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : mc_mem_timer
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl
// Purpose  : Multi-cycle CPU control FSM (IF, ID, EXE, MEM, WB) sharing one
//            memory port between fetch and data access, with run/halt/step
//            debug control, retired-instruction counter and error trap.
// Ports    : clk    - clock
//            resetn - synchronous active-low reset
//            bus    - multi_cycle_ctrl_if.master: run/step, decoder flags,
//                     mem handshake, datapath enables, state/halted/exc,
//                     retire_cnt
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = C_MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    multi_cycle_ctrl_if.master bus
);

    state_t           state_q;
    state_t           state_d;
    logic             exc_q;
    logic             exc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Ungated enables; the port versions are forced low while in reset.
    logic             mem_req_raw;
    logic             mem_we_raw;
    logic             ir_wen_raw;
    logic             pc_wen_raw;
    logic             rf_wen_raw;
    logic             addr_sel;
    logic             pc_sel;
    logic             wb_sel;
    logic             retire;

    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_expired;

    // ------------------------------------------------------------------
    // Memory wait timer: restarts on every state change, so each IF or
    // MEM visit gets a fresh budget; counts only cycles with no ack.
    // ------------------------------------------------------------------
    assign tmr_clr = (state_d != state_q);
    assign tmr_en  = is_mem_state(state_q) && !bus.mem_ack;

    mc_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_timer (
        .clk       (clk),
        .resetn    (resetn),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_req_raw = 1'b0;
        mem_we_raw  = 1'b0;
        ir_wen_raw  = 1'b0;
        pc_wen_raw  = 1'b0;
        rf_wen_raw  = 1'b0;
        addr_sel    = C_ADDR_SEL_PC;
        pc_sel      = C_PC_SEL_SEQ;
        wb_sel      = C_WB_SEL_ALU;
        retire      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // step is only looked at here, so one pulse = one instruction.
                if (bus.run || bus.step) begin
                    state_d = ST_IF;
                end
            end

            ST_IF: begin
                mem_req_raw = 1'b1;
                addr_sel    = C_ADDR_SEL_PC;
                ir_wen_raw  = bus.mem_ack;
                // An ack in the expiry cycle still completes normally.
                if (bus.mem_ack) begin
                    state_d = ST_ID;
                end else if (tmr_expired) begin
                    state_d = ST_ERR;
                end
            end

            ST_ID: begin
                state_d = bus.dec_valid ? ST_EXE : ST_ERR;
            end

            ST_EXE: begin
                if (bus.dec_load || bus.dec_store) begin
                    state_d = ST_MEM;
                end else if (bus.dec_wb) begin
                    state_d = ST_WB;
                end else begin
                    // Branch/jump (or no-op): PC update is the whole effect.
                    retire = 1'b1;
                    pc_sel = bus.dec_jbr ? C_PC_SEL_TGT : C_PC_SEL_SEQ;
                end
            end

            ST_MEM: begin
                mem_req_raw = 1'b1;
                addr_sel    = C_ADDR_SEL_ALU;
                mem_we_raw  = bus.dec_store;
                if (bus.mem_ack) begin
                    if (bus.dec_load) begin
                        state_d = ST_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_ERR;
                end
            end

            ST_WB: begin
                rf_wen_raw = 1'b1;
                wb_sel     = bus.dec_load ? C_WB_SEL_MEM : C_WB_SEL_ALU;
                retire     = 1'b1;
            end

            ST_ERR: begin
                // Trap: only reset leaves this state.
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Common retire action: one-cycle PC update, then continue or halt.
        if (retire) begin
            pc_wen_raw = 1'b1;
            state_d    = bus.run ? ST_IF : ST_IDLE;
        end
    end

    always_comb begin
        exc_d = exc_q | (state_d == ST_ERR);
        cnt_d = cnt_q;
        if (pc_wen_raw) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            exc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Enables are masked by resetn so a reset arriving mid
    // instruction can never cause a PC, regfile or memory write.
    // ------------------------------------------------------------------
    assign bus.mem_req      = mem_req_raw & resetn;
    assign bus.mem_we       = mem_we_raw  & resetn;
    assign bus.ir_wen       = ir_wen_raw  & resetn;
    assign bus.pc_wen       = pc_wen_raw  & resetn;
    assign bus.rf_wen       = rf_wen_raw  & resetn;
    assign bus.mem_addr_sel = addr_sel;
    assign bus.pc_sel       = pc_sel;
    assign bus.wb_sel       = wb_sel;
    assign bus.state        = state_q;
    assign bus.halted       = (state_q == ST_IDLE);
    assign bus.exc          = exc_q;
    assign bus.retire_cnt   = cnt_q;

endmodule : multi_cycle_ctrl
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multi_cycle_ctrl
// Purpose  : Self-checking bench for multi_cycle_ctrl. Stimulus pushes one
//            expected output record per clock cycle into a queue; a monitor
//            pops and compares on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_ctrl;
    import multi_cycle_ctrl_pkg::*;

    localparam int CW = 4;
    localparam int TO = 16;

    // Expected-state encodings
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_EXE  = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    // Enable vectors: {mem_req, mem_we, addr_sel, ir_wen, pc_wen, pc_sel, rf_wen, wb_sel}
    localparam logic [7:0] EN_NONE    = 8'b0000_0000;
    localparam logic [7:0] EN_IF      = 8'b1000_0000;
    localparam logic [7:0] EN_IF_ACK  = 8'b1001_0000;
    localparam logic [7:0] EN_LD      = 8'b1010_0000;
    localparam logic [7:0] EN_ST      = 8'b1110_0000;
    localparam logic [7:0] EN_ST_ACK  = 8'b1110_1000;
    localparam logic [7:0] EN_WB_ALU  = 8'b0000_1010;
    localparam logic [7:0] EN_WB_LD   = 8'b0000_1011;
    localparam logic [7:0] EN_BR_T    = 8'b0000_1100;
    localparam logic [7:0] EN_BR_NT   = 8'b0000_1000;
    localparam logic [7:0] EN_MEM_RST = 8'b0010_0000;

    typedef enum {K_ALU, K_LOAD, K_STORE, K_BR_T, K_BR_NT} kind_t;

    typedef struct {
        string         nm;
        logic [2:0]    st;
        logic [7:0]    en;
        logic          hl;
        logic          ex;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          resetn;
    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_chk;
    int            n_fail;
    logic [CW-1:0] exp_cnt;
    logic [7:0]    act_en;
    logic [2:0]    act_st;

    multi_cycle_ctrl_if #(.CNT_W(CW)) bus ();

    multi_cycle_ctrl #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act_en = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_wen,
                     bus.pc_wen, bus.pc_sel, bus.rf_wen, bus.wb_sel};
    assign act_st = bus.state;

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_chk++;
            if ({act_st, act_en, bus.halted, bus.exc, bus.retire_cnt} !==
                {mon_e.st, mon_e.en, mon_e.hl, mon_e.ex, mon_e.cnt}) begin
                n_fail++;
                $display("FAIL %s @%0t: got st=%0d en=%b halted=%b exc=%b cnt=%0d, want st=%0d en=%b halted=%b exc=%b cnt=%0d",
                         mon_e.nm, $time, act_st, act_en, bus.halted, bus.exc, bus.retire_cnt,
                         mon_e.st, mon_e.en, mon_e.hl, mon_e.ex, mon_e.cnt);
            end
        end
    end

    // One clock cycle: drive ack, queue the expected outputs, advance.
    task automatic cyc(input string nm, input logic ack, input logic [2:0] st,
                       input logic [7:0] en, input logic ex);
        exp_t e;
        bus.mem_ack = ack;
        e.nm  = nm;
        e.st  = st;
        e.en  = en;
        e.hl  = (st == S_IDLE);
        e.ex  = ex;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One complete instruction starting in IF; stray drives mem_ack in
    // cycles where no request is outstanding.
    task automatic instr(input string nm, input kind_t k, input int if_wait,
                         input int mem_wait, input logic stray);
        bus.dec_valid = 1'b1;
        bus.dec_load  = (k == K_LOAD);
        bus.dec_store = (k == K_STORE);
        bus.dec_wb    = (k == K_ALU) || (k == K_LOAD);
        bus.dec_jbr   = (k == K_BR_T);
        for (int w = 0; w < if_wait; w++) cyc(nm, 1'b0, S_IF, EN_IF, 1'b0);
        cyc(nm, 1'b1, S_IF, EN_IF_ACK, 1'b0);
        cyc(nm, stray, S_ID, EN_NONE, 1'b0);
        case (k)
            K_BR_T:  cyc(nm, stray, S_EXE, EN_BR_T, 1'b0);
            K_BR_NT: cyc(nm, stray, S_EXE, EN_BR_NT, 1'b0);
            K_ALU: begin
                cyc(nm, stray, S_EXE, EN_NONE, 1'b0);
                cyc(nm, stray, S_WB, EN_WB_ALU, 1'b0);
            end
            K_STORE: begin
                cyc(nm, stray, S_EXE, EN_NONE, 1'b0);
                for (int w = 0; w < mem_wait; w++) cyc(nm, 1'b0, S_MEM, EN_ST, 1'b0);
                cyc(nm, 1'b1, S_MEM, EN_ST_ACK, 1'b0);
            end
            default: begin
                cyc(nm, stray, S_EXE, EN_NONE, 1'b0);
                for (int w = 0; w < mem_wait; w++) cyc(nm, 1'b0, S_MEM, EN_LD, 1'b0);
                cyc(nm, 1'b1, S_MEM, EN_LD, 1'b0);
                cyc(nm, stray, S_WB, EN_WB_LD, 1'b0);
            end
        endcase
        exp_cnt     = exp_cnt + 1'b1;
        bus.mem_ack = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        n_chk         = 0;
        n_fail        = 0;
        exp_cnt       = '0;
        resetn        = 1'b0;
        bus.run       = 1'b0;
        bus.step      = 1'b0;
        bus.dec_valid = 1'b0;
        bus.dec_load  = 1'b0;
        bus.dec_store = 1'b0;
        bus.dec_wb    = 1'b0;
        bus.dec_jbr   = 1'b0;
        bus.mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then idle with run=0
        cyc("reset_hold", 1'b0, S_IDLE, EN_NONE, 1'b0);
        resetn = 1'b1;
        cyc("idle_halted", 1'b1, S_IDLE, EN_NONE, 1'b0);

        // Free-run sequence of instruction types
        bus.run = 1'b1;
        cyc("idle_to_if", 1'b0, S_IDLE, EN_NONE, 1'b0);
        for (int i = 0; i < 3; i++) instr("alu", K_ALU, 0, 0, 1'b0);
        instr("load_wait3", K_LOAD, 0, 3, 1'b0);
        instr("store_ifwait", K_STORE, 1, 0, 1'b1);
        instr("branch_taken", K_BR_T, 0, 0, 1'b0);
        instr("branch_not_taken", K_BR_NT, 0, 0, 1'b1);
        instr("alu_ifwait2", K_ALU, 2, 0, 1'b1);

        // Drop run with an instruction already in flight
        bus.run = 1'b0;
        instr("alu_run_drop", K_ALU, 0, 0, 1'b0);
        cyc("halt_after_drop", 1'b1, S_IDLE, EN_NONE, 1'b0);
        cyc("halt_after_drop", 1'b0, S_IDLE, EN_NONE, 1'b0);

        // Single step
        bus.step = 1'b1;
        cyc("step_pulse", 1'b0, S_IDLE, EN_NONE, 1'b0);
        bus.step = 1'b0;
        instr("step_load", K_LOAD, 0, 1, 1'b0);
        cyc("halt_after_step", 1'b0, S_IDLE, EN_NONE, 1'b0);
        cyc("halt_after_step", 1'b0, S_IDLE, EN_NONE, 1'b0);

        // Counter wrap (4-bit counter in this bench)
        bus.run = 1'b1;
        cyc("idle_to_if2", 1'b0, S_IDLE, EN_NONE, 1'b0);
        while (exp_cnt != {CW{1'b1}}) instr("alu_fill", K_ALU, 0, 0, 1'b0);
        instr("alu_wrap", K_ALU, 0, 0, 1'b0);
        instr("alu_post_wrap", K_ALU, 0, 0, 1'b0);

        // Reset in the middle of a load's MEM phase, with ack present
        bus.dec_valid = 1'b1;
        bus.dec_load  = 1'b1;
        bus.dec_store = 1'b0;
        bus.dec_wb    = 1'b1;
        bus.dec_jbr   = 1'b0;
        cyc("rst_ld", 1'b1, S_IF, EN_IF_ACK, 1'b0);
        cyc("rst_ld", 1'b0, S_ID, EN_NONE, 1'b0);
        cyc("rst_ld", 1'b0, S_EXE, EN_NONE, 1'b0);
        cyc("rst_ld", 1'b0, S_MEM, EN_LD, 1'b0);
        resetn = 1'b0;
        cyc("rst_in_mem", 1'b1, S_MEM, EN_MEM_RST, 1'b0);
        resetn  = 1'b1;
        bus.run = 1'b0;
        exp_cnt = '0;
        cyc("after_rst", 1'b0, S_IDLE, EN_NONE, 1'b0);
        cyc("after_rst", 1'b0, S_IDLE, EN_NONE, 1'b0);

        // Fetch timeout: 16 IF cycles without ack, then sticky ERR
        bus.run = 1'b1;
        cyc("idle_to_if3", 1'b0, S_IDLE, EN_NONE, 1'b0);
        for (int i = 0; i < TO; i++) cyc("if_timeout", 1'b0, S_IF, EN_IF, 1'b0);
        for (int i = 0; i < 100; i++) begin
            bus.step = i[0];
            cyc("err_hold", i[1], S_ERR, EN_NONE, 1'b1);
        end
        bus.step = 1'b0;
        resetn   = 1'b0;
        cyc("err_reset", 1'b0, S_ERR, EN_NONE, 1'b1);
        resetn  = 1'b1;
        bus.run = 1'b0;
        cyc("err_cleared", 1'b0, S_IDLE, EN_NONE, 1'b0);

        // Illegal instruction traps from ID
        bus.run       = 1'b1;
        bus.dec_valid = 1'b0;
        cyc("idle_to_if4", 1'b0, S_IDLE, EN_NONE, 1'b0);
        cyc("illegal", 1'b1, S_IF, EN_IF_ACK, 1'b0);
        cyc("illegal", 1'b0, S_ID, EN_NONE, 1'b0);
        for (int i = 0; i < 3; i++) cyc("illegal_err", 1'b0, S_ERR, EN_NONE, 1'b1);

        // Every queued expectation must have been consumed
        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_multi_cycle_ctrl
`default_nettype wire
